// File: rtl/rtc_pkg.sv
// Shared constants, time-of-day record and hour formatting for the HH:MM:SS counter.
package rtc_pkg;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] DP_SEP  = 6'b010100;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_time_t;

  // 24-hour value to 1..12 display hour; midnight and noon both show 12.
  function automatic logic [4:0] to12h(input logic [4:0] hr);
    if (hr == 5'd0)
      return 5'd12;
    else if (hr > 5'd12)
      return hr - 5'd12;
    else
      return hr;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Clock prescaler producing the one-cycle time-advance strobe at the normal or fast rate.
module rtc_prescaler #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int FAST_DIV = 10,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic fast,
  input  logic clr,
  output logic tick_stb
);

  localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(CLK_FREQ / FAST_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic             fast_q;
  logic             fast_chg;

  always_comb begin
    lim      = fast ? LIM_FAST : LIM_SLOW;
    fast_chg = fast ^ fast_q;
    tick_stb = run & ~fast_chg & (cnt == lim);
  end

  // A rate change restarts the count so cnt can never sit above the new limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      fast_q <= fast;
    end else begin
      fast_q <= fast;
      if (clr || fast_chg)
        cnt <= '0;
      else if (run)
        cnt <= (cnt == lim) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// HH:MM:SS time-of-day counter with 12/24 h display formatting for the 6-digit display.
// Optional alarm block enabled by defining RTC_ALARM_EN.
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int FAST_DIV = 10,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        fast,
  input  logic        mode_12h,
  input  logic        set_valid,
  input  logic [4:0]  set_hr,
  input  logic [5:0]  set_min,
  input  logic [5:0]  set_sec,
  output logic        set_err,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        en,
  output logic        sign,
  output logic        pm,
  output logic        tick,
  output logic        day_wrap
`ifdef RTC_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [4:0]  alarm_hr,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_on,
  input  logic        alarm_ack,
  output logic        alarm_ring
`endif
);

  rtc_time_t   t;
  rtc_time_t   t_inc;
  logic        tick_stb;
  logic        load_ok;
  logic        load_bad;
  logic        tick_app;
  logic        wrap_now;
  logic        tick_d;
  logic        dw_d;
  logic        al_bad;
  logic [4:0]  hd;
  logic [19:0] disp;

  rtc_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .FAST_DIV (FAST_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .fast     (fast),
    .clr      (load_ok),
    .tick_stb (tick_stb)
  );

  always_comb begin
    load_ok  = set_valid && (set_hr <= HR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
    load_bad = set_valid && !load_ok;
    tick_app = tick_stb && !load_ok;

    t_inc    = t;
    wrap_now = 1'b0;
    if (t.sec == SEC_MAX) begin
      t_inc.sec = '0;
      if (t.min == MIN_MAX) begin
        t_inc.min = '0;
        if (t.hr == HR_MAX) begin
          t_inc.hr = '0;
          wrap_now = 1'b1;
        end else begin
          t_inc.hr = t.hr + 5'd1;
        end
      end else begin
        t_inc.min = t.min + 6'd1;
      end
    end else begin
      t_inc.sec = t.sec + 6'd1;
    end

    hd   = mode_12h ? to12h(t.hr) : t.hr;
    disp = 20'(hd) * 20'd10000 + 20'(t.min) * 20'd100 + 20'(t.sec);
  end

  // tick/day_wrap go through one extra stage so they line up with the new data value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t        <= '0;
      data     <= '0;
      point    <= '0;
      en       <= 1'b0;
      sign     <= 1'b0;
      pm       <= 1'b0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
      tick_d   <= 1'b0;
      dw_d     <= 1'b0;
    end else begin
      en       <= 1'b1;
      sign     <= 1'b0;
      data     <= disp;
      pm       <= (t.hr >= 5'd12);
      point    <= t.sec[0] ? 6'b000000 : DP_SEP;
      tick_d   <= tick_app;
      dw_d     <= tick_app & wrap_now;
      tick     <= tick_d;
      day_wrap <= dw_d;
      set_err  <= load_bad | al_bad;
      if (load_ok)
        t <= '{hr: set_hr, min: set_min, sec: set_sec};
      else if (tick_app)
        t <= t_inc;
    end
  end

`ifdef RTC_ALARM_EN
  logic [4:0] al_hr;
  logic [5:0] al_min;
  logic       t_chg;
  logic [5:0] ring_left;

  assign al_bad = alarm_set && ((alarm_hr > HR_MAX) || (alarm_min > MIN_MAX));

  // t_chg marks that t was rewritten last edge, so a match is seen once per arrival.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      al_hr      <= '0;
      al_min     <= '0;
      t_chg      <= 1'b0;
      ring_left  <= '0;
      alarm_ring <= 1'b0;
    end else begin
      if (alarm_set && !al_bad) begin
        al_hr  <= alarm_hr;
        al_min <= alarm_min;
      end
      t_chg <= load_ok | tick_app;
      if (alarm_ack || !alarm_on) begin
        alarm_ring <= 1'b0;
        ring_left  <= '0;
      end else if (t_chg && (t.hr == al_hr) && (t.min == al_min) && (t.sec == 6'd0)) begin
        alarm_ring <= 1'b1;
        ring_left  <= 6'd60;
      end else if (alarm_ring && tick_app) begin
        if (ring_left == 6'd1)
          alarm_ring <= 1'b0;
        ring_left <= ring_left - 6'd1;
      end
    end
  end
`else
  assign al_bad = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Self-checking bench for rtc_hms_counter: directed scenarios plus random traffic vs a seconds-of-day model.
module tb_rtc_hms_counter;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        fast;
  logic        mode_12h;
  logic        set_valid;
  logic [4:0]  set_hr;
  logic [5:0]  set_min;
  logic [5:0]  set_sec;
  logic        set_err;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic        pm;
  logic        tick;
  logic        day_wrap;
`ifdef RTC_ALARM_EN
  logic        alarm_set;
  logic [4:0]  alarm_hr;
  logic [5:0]  alarm_min;
  logic        alarm_on;
  logic        alarm_ack;
  logic        alarm_ring;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: time as seconds since midnight
  int   m_tod, m_pc;
  bit   m_fq, p_tick, p_dw;
  int   e_data;
  bit   e_pm, e_en, e_tick, e_dw, e_err;
  logic [5:0] e_point;

  rtc_hms_counter #(
    .CLK_FREQ (100),
    .FAST_DIV (10),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .fast      (fast),
    .mode_12h  (mode_12h),
    .set_valid (set_valid),
    .set_hr    (set_hr),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_err   (set_err),
    .data      (data),
    .point     (point),
    .en        (en),
    .sign      (sign),
    .pm        (pm),
    .tick      (tick),
    .day_wrap  (day_wrap)
`ifdef RTC_ALARM_EN
    ,
    .alarm_set  (alarm_set),
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .alarm_on   (alarm_on),
    .alarm_ack  (alarm_ack),
    .alarm_ring (alarm_ring)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int disp_of(input int tod, input bit m12);
    int h, mi, s;
    h  = tod / 3600;
    mi = (tod / 60) % 60;
    s  = tod % 60;
    if (m12) begin
      if (h == 0)
        h = 12;
      else if (h > 12)
        h = h - 12;
    end
    return h * 10000 + mi * 100 + s;
  endfunction

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic m_edge();
    int L;
    bit fchg, tk, ok;
    if (!rst_n) begin
      m_tod = 0; m_pc = 0; m_fq = fast; p_tick = 0; p_dw = 0;
      e_data = 0; e_point = 6'b0; e_en = 0; e_pm = 0; e_tick = 0; e_dw = 0; e_err = 0;
      return;
    end
    e_data  = disp_of(m_tod, mode_12h);
    e_pm    = (m_tod >= 12 * 3600);
    e_point = ((m_tod % 60) % 2 == 0) ? 6'b010100 : 6'b000000;
    e_en    = 1;
    e_tick  = p_tick;
    e_dw    = p_dw;
    L    = fast ? 10 : 100;
    fchg = (fast != m_fq);
    tk   = run && (m_pc == L - 1) && !fchg;
    ok   = set_valid && (set_hr <= 23) && (set_min <= 59) && (set_sec <= 59);
    e_err  = set_valid && !ok;
    p_tick = 0;
    p_dw   = 0;
    if (ok) begin
      m_tod = set_hr * 3600 + set_min * 60 + set_sec;
      m_pc  = 0;
    end else begin
      if (fchg)
        m_pc = 0;
      else if (run)
        m_pc = (m_pc + 1) % L;
      if (tk) begin
        p_tick = 1;
        p_dw   = (m_tod == 86399);
        m_tod  = (m_tod + 1) % 86400;
      end
    end
    m_fq = fast;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("data", 32'(data), 32'(e_data));
    chk("point", 32'(point), 32'(e_point));
    chk("pm", 32'(pm), 32'(e_pm));
    chk("en", 32'(en), 32'(e_en));
    chk("sign", 32'(sign), 32'd0);
    chk("tick", 32'(tick), 32'(e_tick));
    chk("day_wrap", 32'(day_wrap), 32'(e_dw));
    chk("set_err", 32'(set_err), 32'(e_err));
  endtask

  task automatic load(input int h, input int mi, input int s);
    set_hr = 5'(h); set_min = 6'(mi); set_sec = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  initial begin
    int ntk, ndw, nboth, n, exp_n;
    rst_n = 0; run = 0; fast = 0; mode_12h = 0; set_valid = 0;
    set_hr = 0; set_min = 0; set_sec = 0;
`ifdef RTC_ALARM_EN
    alarm_set = 0; alarm_hr = 0; alarm_min = 0; alarm_on = 0; alarm_ack = 0;
`endif
    m_tod = 0; m_pc = 0; m_fq = 0; p_tick = 0; p_dw = 0;
    #1;
    step(); step();
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_en", 32'(en), 32'd0);

    // 1 s ticks from reset
    rst_n = 1; run = 1;
    ntk = 0;
    repeat (302) begin step(); if (tick) ntk++; end
    chk("ticks_302", 32'(ntk), 32'd3);
    chk("data_after_3", 32'(data), 32'd3);

    // midnight rollover at fast rate
    fast = 1; step();
    load(23, 59, 58);
    ntk = 0; ndw = 0; nboth = 0;
    repeat (25) begin
      step();
      if (tick) ntk++;
      if (day_wrap) ndw++;
      if (tick && day_wrap) nboth++;
    end
    chk("wrap_ticks", 32'(ntk), 32'd2);
    chk("wrap_count", 32'(nboth), 32'd1);
    chk("wrap_dw", 32'(ndw), 32'd1);
    chk("wrap_data", 32'(data), 32'd0);
    chk("wrap_pm", 32'(pm), 32'd0);

    // 12-hour display
    mode_12h = 1;
    load(0, 30, 0); step();
    chk("h12_midnight", 32'(data), 32'd123000);
    chk("h12_pm0", 32'(pm), 32'd0);
    load(13, 5, 7); step();
    chk("h12_afternoon", 32'(data), 32'd10507);
    chk("h12_pm1", 32'(pm), 32'd1);
    mode_12h = 0;

    // rejected load
    set_hr = 1; set_min = 60; set_sec = 0; set_valid = 1;
    step();
    set_valid = 0;
    chk("err_pulse", 32'(set_err), 32'd1);
    step();
    chk("err_clear", 32'(set_err), 32'd0);
    chk("err_data_kept", 32'(data), 32'd130507);

    // valid load colliding with a tick strobe
    n = 0;
    while (m_pc != 9 && n < 50) begin step(); n++; end
    chk("collide_reach", 32'(m_pc), 32'd9);
    load(5, 6, 7);
    ntk = 0;
    repeat (3) begin step(); if (tick) ntk++; end
    chk("collide_data", 32'(data), 32'd50607);
    chk("collide_notick", 32'(ntk), 32'd0);

    // pause and resume at 1 s rate
    fast = 0;
    repeat (30) step();
    run = 0;
    ntk = 0;
    for (int i = 0; i < 250; i++) begin step(); if (i >= 2 && tick) ntk++; end
    chk("pause_notick", 32'(ntk), 32'd0);
    exp_n = 101 - m_pc;
    run = 1;
    n = 0;
    do begin step(); n++; end while (!tick && n < 200);
    chk("resume_latency", 32'(n), 32'(exp_n));

    // rate change mid-count
    n = 0;
    while (m_pc != 50 && n < 200) begin step(); n++; end
    chk("fast_reach50", 32'(m_pc), 32'd50);
    fast = 1;
    n = 0;
    do begin step(); n++; end while (!tick && n < 200);
    chk("fast_toggle_latency", 32'(n), 32'd12);

`ifdef RTC_ALARM_EN
    alarm_hr = 5'd0; alarm_min = 6'd1; alarm_on = 1; alarm_set = 1;
    step();
    alarm_set = 0;
    load(0, 0, 59);
    n = 0;
    do begin step(); n++; end while (!tick && n < 100);
    chk("alarm_ring_on", 32'(alarm_ring), 32'd1);
    alarm_ack = 1; step(); alarm_ack = 0;
    chk("alarm_ring_ack", 32'(alarm_ring), 32'd0);
    alarm_on = 0;
`endif

    // synchronous reset mid-run
    load(12, 34, 56); step();
    chk("pre_rst_data", 32'(data), 32'd123456);
    rst_n = 0; step(); rst_n = 1;
    chk("srst_data", 32'(data), 32'd0);
    chk("srst_en", 32'(en), 32'd0);
    chk("srst_point", 32'(point), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      run       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) fast = ~fast;
      if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
      set_valid = ($urandom_range(0, 29) == 0);
      set_hr    = 5'($urandom_range(0, 31));
      set_min   = 6'($urandom_range(0, 63));
      set_sec   = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 63));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
